// File: rtl/tick_ctrl.sv
// Tick controller: debounced run/pause and speed buttons driving a shift-enable strobe.
// Define TICK_CTRL_DIR_EN to add the BTN_DIR button and dir output.
module tick_ctrl_db #(
  parameter int DB_N = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [DB_N-1:0] cnt_q, cnt_d;

  // Next debounce state: flip the level only after 2^DB_N consecutive mismatching samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + DB_N'(1);
    end
  end

  assign rise_o = level_d & ~level_q;

  // Synchronizer and debounce registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

module tick_ctrl #(
  parameter int N    = 24,
  parameter int DB_N = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_PAUSE,
  input  logic       BTN_SPEED,
`ifdef TICK_CTRL_DIR_EN
  input  logic       BTN_DIR,
  output logic       dir,
`endif
  output logic       shift_en,
  output logic       running,
  output logic [1:0] speed
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_PAUSE = 1'b1;

  logic         pause_rise_s, speed_rise_s;
  logic         pause_evt_q, speed_evt_q;
  logic [0:0]   state_q, state_d;
  logic [1:0]   speed_q, speed_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] term_q, term_d;
  logic         shift_q, shift_d;
  logic         running_q, running_d;

  tick_ctrl_db #(.DB_N(DB_N)) u_db_pause (
    .clk_i  (CLK),
    .rst_i  (RST),
    .btn_i  (BTN_PAUSE),
    .rise_o (pause_rise_s)
  );

  tick_ctrl_db #(.DB_N(DB_N)) u_db_speed (
    .clk_i  (CLK),
    .rst_i  (RST),
    .btn_i  (BTN_SPEED),
    .rise_o (speed_rise_s)
  );

  // term_q tracks the terminal count of the period at the current speed.
  assign term_q = {N{1'b1}} >> speed_q;

  // Next state, speed, period counter and look-ahead for the registered outputs.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    if (pause_evt_q) begin
      case (state_q)
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end else begin
      state_d = state_q;
    end
    if (speed_evt_q) begin
      speed_d = speed_q + 2'd1;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      if (cnt_q >= term_q) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + N'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
    term_d    = {N{1'b1}} >> speed_d;
    // A speed event next cycle clears the counter, so it must also mask the strobe.
    shift_d   = (state_d == ST_RUN) && (cnt_d == term_d) && !speed_rise_s;
    running_d = (state_d == ST_RUN);
  end

  // Control registers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pause_evt_q <= 1'b0;
      speed_evt_q <= 1'b0;
      state_q     <= ST_RUN;
      speed_q     <= 2'd0;
      cnt_q       <= '0;
      shift_q     <= 1'b0;
      running_q   <= 1'b1;
    end else begin
      pause_evt_q <= pause_rise_s;
      speed_evt_q <= speed_rise_s;
      state_q     <= state_d;
      speed_q     <= speed_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      running_q   <= running_d;
    end
  end

  assign shift_en = shift_q;
  assign running  = running_q;
  assign speed    = speed_q;

`ifdef TICK_CTRL_DIR_EN
  logic dir_rise_s;
  logic dir_evt_q;
  logic dir_q, dir_d;

  tick_ctrl_db #(.DB_N(DB_N)) u_db_dir (
    .clk_i  (CLK),
    .rst_i  (RST),
    .btn_i  (BTN_DIR),
    .rise_o (dir_rise_s)
  );

  // Direction toggles once per debounced press.
  always_comb begin
    if (dir_evt_q) begin
      dir_d = ~dir_q;
    end else begin
      dir_d = dir_q;
    end
  end

  // Direction registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dir_evt_q <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      dir_evt_q <= dir_rise_s;
      dir_q     <= dir_d;
    end
  end

  assign dir = dir_q;
`endif

endmodule
